// File: rtl/serial_operand_sender.sv
// Serializes an operand pair LSB first; first bit 1 cycle after accept, stall freezes the bit in flight.
// Macro SERIAL_OPERAND_SENDER_SKID_EN adds a one-entry buffer for zero-gap back-to-back words.
module serial_operand_sender #(
    parameter int W  = 8,
    parameter int LW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [LW-1:0] in_len,
    input  logic          stall,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [LW-1:0] LEN_MAX = LW'(W);

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt;
    logic [LW-1:0] r_cnt, w_cnt_nxt;
    logic [LW-1:0] w_len_eff;
    logic          w_accept;

    // Zero and out-of-range lengths both mean a full-width word.
    assign w_len_eff = (in_len == '0 || in_len > LEN_MAX) ? LEN_MAX : in_len;
    assign w_accept  = in_vld & in_rdy;

    assign vld  = (r_state == SHIFT) & ~stall;
    assign a    = vld & r_sh_a[0];
    assign b    = vld & r_sh_b[0];
    assign last = vld & (r_cnt == LW'(1));

`ifdef SERIAL_OPERAND_SENDER_SKID_EN
    logic          r_skid_vld, w_skid_vld_nxt;
    logic [W-1:0]  r_skid_a, r_skid_b, w_skid_a_nxt, w_skid_b_nxt;
    logic [LW-1:0] r_skid_len, w_skid_len_nxt;

    assign in_rdy = ~r_skid_vld;

    always_comb begin
        w_state_nxt    = r_state;
        w_sh_a_nxt     = r_sh_a;
        w_sh_b_nxt     = r_sh_b;
        w_cnt_nxt      = r_cnt;
        w_skid_vld_nxt = r_skid_vld;
        w_skid_a_nxt   = r_skid_a;
        w_skid_b_nxt   = r_skid_b;
        w_skid_len_nxt = r_skid_len;
        if (vld) begin
            w_sh_a_nxt = {1'b0, r_sh_a[W-1:1]};
            w_sh_b_nxt = {1'b0, r_sh_b[W-1:1]};
            w_cnt_nxt  = r_cnt - LW'(1);
        end
        if (last) begin
            // Buffered word (or one arriving this very edge) follows with no gap.
            if (r_skid_vld) begin
                w_sh_a_nxt     = r_skid_a;
                w_sh_b_nxt     = r_skid_b;
                w_cnt_nxt      = r_skid_len;
                w_skid_vld_nxt = 1'b0;
            end else if (w_accept) begin
                w_sh_a_nxt = in_a;
                w_sh_b_nxt = in_b;
                w_cnt_nxt  = w_len_eff;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                w_sh_a_nxt  = in_a;
                w_sh_b_nxt  = in_b;
                w_cnt_nxt   = w_len_eff;
                w_state_nxt = SHIFT;
            end else begin
                w_skid_vld_nxt = 1'b1;
                w_skid_a_nxt   = in_a;
                w_skid_b_nxt   = in_b;
                w_skid_len_nxt = w_len_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_vld <= 1'b0;
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_len <= '0;
        end else begin
            r_skid_vld <= w_skid_vld_nxt;
            r_skid_a   <= w_skid_a_nxt;
            r_skid_b   <= w_skid_b_nxt;
            r_skid_len <= w_skid_len_nxt;
        end
    end
`else
    assign in_rdy = (r_state == IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_sh_a_nxt  = r_sh_a;
        w_sh_b_nxt  = r_sh_b;
        w_cnt_nxt   = r_cnt;
        if (vld) begin
            w_sh_a_nxt = {1'b0, r_sh_a[W-1:1]};
            w_sh_b_nxt = {1'b0, r_sh_b[W-1:1]};
            w_cnt_nxt  = r_cnt - LW'(1);
            if (last) begin
                w_state_nxt = IDLE;
            end
        end
        if (w_accept) begin
            w_sh_a_nxt  = in_a;
            w_sh_b_nxt  = in_b;
            w_cnt_nxt   = w_len_eff;
            w_state_nxt = SHIFT;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sh_a  <= w_sh_a_nxt;
            r_sh_b  <= w_sh_b_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
